serializer_stream: RTL and testbench
====================================

# serializer_stream

Parametrised parallel-to-serial transmitter that replaces the fixed 8-bit, divide-by-N transmitter of the SDR front end. It accepts words over a valid/ready stream and shifts them out on `tx`, together with a generated bit clock `txclk` and a per-word frame sync `fs`. Word width, clock divide ratio, bit order and idle line level are parameters. Consecutive words are sent with no gap, and an underrun is flagged when the stream breaks.

## Interface
- `WIDTH`, 8, bits per word, 2 or more
- `DIV`, 16, clk cycles per serial bit, even, 2 or more
- `MSB_FIRST`, 1, 1 sends bit WIDTH-1 first, 0 sends bit 0 first
- `IDLE_LVL`, 0, level of `tx` when no word is being sent

- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, synchronous and active-high
- `oe`  in  1  output enable; gates acceptance of new words
- `s_data`  in  WIDTH  word to transmit
- `s_valid`  in  1  `s_data` is valid
- `s_ready`  out  1  block will accept `s_data` at this clock edge
- `clr_underrun`  in  1  clears `underrun` (one-cycle pulse)
- `txclk`  out  1  serial bit clock
- `tx`  out  1  serial data
- `fs`  out  1  high for the whole first bit period of each word
- `busy`  out  1  a word is being shifted out
- `underrun`  out  1  sticky stream-break flag

## Operation
- Storage: one holding register (`hold`, `hold_valid`), one shift register, `div_cnt` (0..DIV-1) and `bit_cnt` (0..WIDTH-1).
- `s_ready = oe & ~hold_valid`, combinational. The handshake is `s_valid & s_ready` at a rising edge: `hold <= s_data` and `hold_valid <= 1`.
- The FSM has two states, IDLE and SHIFT.
- IDLE to SHIFT: when `hold_valid` is set, the word moves from `hold` to the shift register at the edge and `hold_valid` clears. `div_cnt` and `bit_cnt` reset to 0.
- SHIFT:
  - `div_cnt` increments on every cycle.
  - At `div_cnt == DIV-1`, `div_cnt` wraps to 0 and the next bit is presented.
  - At the last bit (`bit_cnt == WIDTH-1`) with `div_cnt == DIV-1`: if `hold_valid` is set, the next word loads seamlessly and the FSM stays in SHIFT. Otherwise the FSM returns to IDLE.
- Word completion with `hold_valid == 0` and `oe == 1` sets `underrun`.
- `underrun` clears only on `rst` or `clr_underrun`. If `clr_underrun` and a set event occur in the same cycle, set wins.
- `oe` deassert: the current word always completes, and a word already in `hold` is still sent. No new handshakes occur while `oe == 0`, and no underrun is raised while `oe == 0`.
- `tx` shows the current bit of the shift register, in the order set by `MSB_FIRST`. In IDLE, `tx = IDLE_LVL`.
- `txclk` is low for `div_cnt` 0..DIV/2-1 and high for `div_cnt` DIV/2..DIV-1. It is held at 0 in IDLE.
- `fs = busy & (bit_cnt == 0)`.
- `busy` is 1 exactly in SHIFT.
- `rst` applies mid-operation: the next cycle is in IDLE, `hold_valid = 0`, and any partially sent or held word is discarded.

## Timing
- Reset values: `tx = IDLE_LVL`; `txclk`, `fs`, `busy`, `underrun` and `s_ready` all 0. `s_ready` rises the cycle after `rst` falls if `oe = 1`.
- All outputs except `s_ready` are registered.
- Latency: a handshake at edge E0 puts the first bit on `tx` (with `fs = 1`, `busy = 1`) in the cycle after edge E0+1, i.e. 2 edges after accept.
- Each bit lasts DIV cycles and each word lasts WIDTH·DIV cycles.
- `tx` changes together with the falling edge of `txclk`; `txclk` rises at mid-bit.
- Back-to-back words have no idle cycle between the last bit of one word and the first bit of the next.
- `s_ready` reasserts the cycle after the hold-to-shift transfer. The next word may be accepted at any point before the current word ends.

## Test plan
WIDTH=8, DIV=4, MSB_FIRST=1, IDLE_LVL=0 unless stated otherwise.

1. Assert `rst` for 3 cycles with `oe=1` -> all outputs at reset values during reset; `s_ready=1` in the first cycle after release.
2. Send a single word 0xA5 -> `tx` = 1,0,1,0,0,1,0,1, each bit held 4 cycles; `txclk` shows 8 periods of 0,0,1,1; `fs` high for 4 cycles; `busy` high for 32 cycles; then IDLE with `underrun=1`.
3. Hold `s_valid` high with data 0x00..0x0F -> 128 bits gapless; `fs` pulses every 32 cycles; `underrun` stays 0 until the word after 0x0F is due.
4. MSB_FIRST=0, IDLE_LVL=1, word 0x01 -> `tx` = 1,0,0,0,0,0,0,0, then 1 when idle; `clr_underrun` pulse -> `underrun=0`.
5. Drop `oe` at bit 3 of word 0x3C with a word already held -> 0x3C completes, the held word is sent, `s_ready` stays 0, `underrun` stays 0.
6. Assert `rst` at bit 5 of a word -> next cycle `busy=0`, `tx=IDLE_LVL`, `txclk=0`; the held word is not sent after release.

Source files
------------

// File: rtl/serializer_stream.sv
// Parallel-to-serial transmitter: words from a valid/ready stream are shifted out
// on tx with a generated bit clock (txclk) and a first-bit frame sync (fs).
// Latency: first bit on tx two edges after the accepting edge; WIDTH*DIV cycles per word.
// Backpressure: s_ready = oe & ~hold_valid; a single holding register gives gapless back-to-back words.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   oe                 output enable, gates acceptance of new words
//   s_data/s_valid/s_ready  input word stream
//   clr_underrun       one-cycle pulse clearing the sticky underrun flag
//   txclk, tx, fs      serial bit clock, serial data, frame sync (registered)
//   busy, underrun     word in flight, sticky stream-break flag (registered)
module serializer_stream #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 16,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             clr_underrun,
    output logic             txclk,
    output logic             tx,
    output logic             fs,
    output logic             busy,
    output logic             underrun
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              underrun_q, underrun_d;
    logic              tx_q, tx_d;
    logic              txclk_q, txclk_d;
    logic              fs_q, fs_d;
    logic              busy_q, busy_d;
    logic              accept;

    // rst gating keeps s_ready low while reset is held.
    assign s_ready  = oe & ~hold_vld_q & ~rst;
    assign accept   = s_valid & s_ready;

    assign tx       = tx_q;
    assign txclk    = txclk_q;
    assign fs       = fs_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = underrun_q;

        // Clear first so a same-cycle set event below overrides it.
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end

        // accept needs hold empty, load needs hold full: never both in one cycle.
        if (accept) begin
            hold_d     = s_data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    state_d    = ST_SHIFT;
                    shift_d    = hold_q;
                    hold_vld_d = 1'b0;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        if (hold_vld_q) begin
                            // Seamless reload: next word's first bit follows immediately.
                            shift_d    = hold_q;
                            hold_vld_d = 1'b0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            if (oe) begin
                                underrun_d = 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (MSB_FIRST != 0) begin
                            shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shift_d = {1'b0, shift_q[WIDTH-1:1]};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        // and aligned with the counters they describe.
        busy_d  = (state_d == ST_SHIFT);
        tx_d    = IDLE_LVL;
        if (busy_d) begin
            tx_d = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
        end
        txclk_d = busy_d & (div_cnt_d >= DIV_HALF);
        fs_d    = busy_d & (bit_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            tx_q       <= IDLE_LVL;
            txclk_q    <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
            tx_q       <= tx_d;
            txclk_q    <= txclk_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_serializer_stream.sv
// Directed bench for serializer_stream: MSB-first/idle-low instance (a) and
// LSB-first/idle-high instance (b), both WIDTH=8, DIV=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serializer_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       oe  = 1'b1;
    logic [7:0] s_data = 8'h00;

    logic       s_valid_a = 1'b0, clr_a = 1'b0;
    logic       s_ready_a, txclk_a, tx_a, fs_a, busy_a, underrun_a;
    logic       s_valid_b = 1'b0, clr_b = 1'b0;
    logic       s_ready_b, txclk_b, tx_b, fs_b, busy_b, underrun_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serializer_stream #(.WIDTH(8), .DIV(4), .MSB_FIRST(1), .IDLE_LVL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .oe(oe), .s_data(s_data), .s_valid(s_valid_a),
        .s_ready(s_ready_a), .clr_underrun(clr_a), .txclk(txclk_a), .tx(tx_a),
        .fs(fs_a), .busy(busy_a), .underrun(underrun_a)
    );

    serializer_stream #(.WIDTH(8), .DIV(4), .MSB_FIRST(0), .IDLE_LVL(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .oe(oe), .s_data(s_data), .s_valid(s_valid_b),
        .s_ready(s_ready_b), .clr_underrun(clr_b), .txclk(txclk_b), .tx(tx_b),
        .fs(fs_b), .busy(busy_b), .underrun(underrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {busy, fs, txclk, tx} for cycle k (0..31) of word w.
    function automatic logic [3:0] exp_bit(input logic [7:0] w, input int k, input bit msb);
        logic b;
        b = msb ? w[7 - k/4] : w[k/4];
        return {1'b1, (k < 4), ((k % 4) >= 2), b};
    endfunction

    initial begin
        logic [7:0] w;
        bit hs;

        // 1. reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_a_out", {busy_a, fs_a, txclk_a, tx_a, underrun_a, s_ready_a}, 6'b0);
            chk("rst_b_out", {busy_b, fs_b, txclk_b, tx_b, underrun_b, s_ready_b}, 6'b000100);
        end
        rst = 1'b0;
        tick();
        chk("rel_rdy", {s_ready_a, s_ready_b}, 2'b11);

        // 4. LSB first, idle high, word 0x01
        s_data = 8'h01; s_valid_b = 1'b1;
        tick();
        s_valid_b = 1'b0;
        chk("b_acc_busy", busy_b, 1'b0);
        tick();
        for (int k = 0; k < 32; k++) begin
            chk("b_word01", {busy_b, fs_b, txclk_b, tx_b}, exp_bit(8'h01, k, 1'b0));
            tick();
        end
        chk("b_idle", {busy_b, tx_b, txclk_b, underrun_b}, 4'b0101);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("b_clr", underrun_b, 1'b0);

        // 2. single word 0xA5
        s_data = 8'hA5; s_valid_a = 1'b1;
        tick();
        s_valid_a = 1'b0;
        chk("a_acc", {busy_a, s_ready_a}, 2'b00);
        tick();
        for (int k = 0; k < 32; k++) begin
            chk("a_wordA5", {busy_a, fs_a, txclk_a, tx_a}, exp_bit(8'hA5, k, 1'b1));
            tick();
        end
        chk("a_end_A5", {busy_a, tx_a, txclk_a, fs_a, underrun_a}, 5'b00001);

        // 3. streaming 0x00..0x0F gapless
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("a_clr", underrun_a, 1'b0);
        s_data = 8'h00; s_valid_a = 1'b1;
        tick();
        s_data = 8'h01;
        tick();
        for (int n = 0; n < 16; n++) begin
            w = 8'(n);
            for (int k = 0; k < 32; k++) begin
                chk("a_stream", {busy_a, fs_a, txclk_a, tx_a}, exp_bit(w, k, 1'b1));
                chk("a_stream_ur", underrun_a, 1'b0);
                hs = s_valid_a & s_ready_a;
                tick();
                if (hs) begin
                    s_data = s_data + 8'd1;
                    if (s_data == 8'h10) s_valid_a = 1'b0;
                end
            end
        end
        chk("a_stream_end", {busy_a, underrun_a}, 2'b01);

        // 5. oe dropped at bit 3 of 0x3C with 0x5A held
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        s_data = 8'h3C; s_valid_a = 1'b1;
        tick();
        s_data = 8'h5A;
        tick();
        for (int k = 0; k < 32; k++) begin
            if (k == 1) s_data = 8'hFF;
            if (k == 12) oe = 1'b0;
            chk("a_word3C", {busy_a, fs_a, txclk_a, tx_a}, exp_bit(8'h3C, k, 1'b1));
            if (k >= 1) chk("a_oe_rdy", s_ready_a, 1'b0);
            tick();
        end
        for (int k = 0; k < 32; k++) begin
            chk("a_word5A", {busy_a, fs_a, txclk_a, tx_a}, exp_bit(8'h5A, k, 1'b1));
            chk("a_oe_rdy_ur", {s_ready_a, underrun_a}, 2'b00);
            tick();
        end
        chk("a_oe_end", {busy_a, underrun_a, s_ready_a, tx_a}, 4'b0000);
        s_valid_a = 1'b0; oe = 1'b1;
        tick();

        // 6. reset at bit 5 of 0x96 with 0x33 held
        s_data = 8'h96; s_valid_a = 1'b1;
        tick();
        s_data = 8'h33;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k == 1) s_valid_a = 1'b0;
            chk("a_word96", {busy_a, fs_a, txclk_a, tx_a}, exp_bit(8'h96, k, 1'b1));
            tick();
        end
        rst = 1'b1;
        tick();
        chk("a_midrst", {busy_a, tx_a, txclk_a, fs_a, s_ready_a}, 5'b00000);
        rst = 1'b0;
        tick();
        chk("a_rel_rdy", s_ready_a, 1'b1);
        for (int k = 0; k < 40; k++) begin
            chk("a_no_held", {busy_a, tx_a}, 2'b00);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
